// File: rtl/gmii_rx_reconcile_pkg.sv
// gmii_rx_reconcile_pkg: shared state encoding, GMII code constants and helpers for the GMII receive reconciliation block
package gmii_rx_reconcile_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_DATA,
    ST_EXTEND,
    ST_DROP
  } state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_FALSE_CARRIER,
    RX_EXTEND,
    RX_EXTEND_ERROR,
    RX_DATA,
    RX_DATA_ERROR,
    RX_RESERVED
  } rx_class_t;

  localparam logic [7:0] PREAMBLE_BYTE   = 8'h55;
  localparam logic [7:0] SFD_BYTE        = 8'hD5;
  localparam logic [7:0] FALSE_CARRIER   = 8'h0E;
  localparam logic [7:0] CARRIER_EXT     = 8'h0F;
  localparam logic [7:0] CARRIER_EXT_ERR = 8'h1F;

  // Where a carrier starting with this byte leads: preamble, straight to data, or junk.
  function automatic state_t sof_state(input logic [7:0] d);
    return d == PREAMBLE_BYTE ? ST_PREAMBLE : d == SFD_BYTE ? ST_DATA : ST_DROP;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return &v ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/gmii_rx_reconcile_decode.sv
// gmii_rx_decode: combinational classification of one GMII receive sample
module gmii_rx_decode
  import gmii_rx_reconcile_pkg::*;
(
  input  logic       rx_dv,
  input  logic       rx_er,
  input  logic [7:0] rxd,
  output rx_class_t  cls
);
  always_comb
    cls = rx_dv ? (rx_er ? RX_DATA_ERROR : RX_DATA) :
          !rx_er ? RX_IDLE :
          rxd == FALSE_CARRIER ? RX_FALSE_CARRIER :
          rxd == CARRIER_EXT ? RX_EXTEND :
          rxd == CARRIER_EXT_ERR ? RX_EXTEND_ERROR : RX_RESERVED;
endmodule

// File: rtl/gmii_rx_reconcile.sv
// gmii_rx_reconcile: GMII receive reconciliation, strips preamble/SFD and reports data, extension and frame status
module gmii_rx_reconcile
  import gmii_rx_reconcile_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rxd,
  input  logic        rx_dv,
  input  logic        rx_er,
  output logic        pls_data_indicate_valid,
  output logic [7:0]  pls_data_indicate_byte,
  output logic        pls_data_indicate_error,
  output logic        pls_data_indicate_extend,
  output logic        pls_data_indicate_extenderror,
  output logic        pls_carrier_indicate,
  output logic        false_carrier,
  output logic        frame_done,
  output logic        frame_error,
  output logic [15:0] byte_count
);
  rx_class_t   cls;
  state_t      state, nxt;
  logic        v, de, ext, exterr, fc, done, clr, bump, seterr, pend, pend_n;
  logic [15:0] cnt_e;
  logic        fe_e;

  gmii_rx_decode u_decode (
    .rx_dv (rx_dv),
    .rx_er (rx_er),
    .rxd   (rxd),
    .cls   (cls)
  );

  // A burst SFD straight out of EXTEND must not disturb the status shown with
  // that cycle's frame_done, so the clear is applied one cycle later via pend.
  assign cnt_e = pend ? 16'd0 : byte_count;
  assign fe_e  = pend ? 1'b0 : frame_error;

  always_comb begin
    nxt    = state;
    v      = 1'b0;
    de     = 1'b0;
    ext    = 1'b0;
    exterr = 1'b0;
    fc     = 1'b0;
    done   = 1'b0;
    clr    = 1'b0;
    bump   = 1'b0;
    seterr = 1'b0;
    pend_n = 1'b0;
    case (state)
      ST_IDLE, ST_PREAMBLE: begin
        nxt = rx_dv ? sof_state(rxd) : ST_IDLE;
        fc  = state == ST_IDLE && cls == RX_FALSE_CARRIER;
        clr = nxt == ST_DATA;
      end
      ST_DATA: begin
        v      = rx_dv;
        bump   = rx_dv;
        de     = cls == RX_DATA_ERROR;
        ext    = cls == RX_EXTEND;
        exterr = cls == RX_EXTEND_ERROR;
        seterr = de || exterr;
        done   = !rx_dv && !ext && !exterr;
        nxt    = rx_dv ? ST_DATA : (ext || exterr) ? ST_EXTEND : ST_IDLE;
      end
      ST_EXTEND: begin
        ext    = cls == RX_EXTEND;
        exterr = !rx_dv && rx_er && !ext;
        seterr = exterr;
        done   = rx_dv || !rx_er;
        nxt    = rx_dv ? sof_state(rxd) : rx_er ? ST_EXTEND : ST_IDLE;
        pend_n = nxt == ST_DATA;
      end
      ST_DROP: nxt = rx_dv ? ST_DROP : ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) state <= reset ? ST_IDLE : nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      pls_data_indicate_valid       <= 1'b0;
      pls_data_indicate_byte        <= 8'h00;
      pls_data_indicate_error       <= 1'b0;
      pls_data_indicate_extend      <= 1'b0;
      pls_data_indicate_extenderror <= 1'b0;
      pls_carrier_indicate          <= 1'b0;
      false_carrier                 <= 1'b0;
      frame_done                    <= 1'b0;
      frame_error                   <= 1'b0;
      byte_count                    <= 16'd0;
      pend                          <= 1'b0;
    end else begin
      pls_data_indicate_valid       <= v;
      pls_data_indicate_byte        <= v ? rxd : 8'h00;
      pls_data_indicate_error       <= de;
      pls_data_indicate_extend      <= ext;
      pls_data_indicate_extenderror <= exterr;
      pls_carrier_indicate          <= nxt != ST_IDLE || fc;
      false_carrier                 <= fc;
      frame_done                    <= done;
      frame_error                   <= !clr && (fe_e || seterr);
      byte_count                    <= clr ? 16'd0 : bump ? sat_inc(cnt_e) : cnt_e;
      pend                          <= pend_n;
    end
  end
endmodule

// File: doc/gmii_rx_reconcile.md
GMII_RX_RECONCILE -- requirements
Module: gmii_rx_reconcile

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all logic on posedge clk.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port: rxd  input  8  GMII receive data.
REQ-004 SHALL have port: rx_dv  input  1  GMII receive data valid.
REQ-005 SHALL have port: rx_er  input  1  GMII receive error.
REQ-006 SHALL have port: pls_data_indicate_valid  output  1  one received frame data byte is on pls_data_indicate_byte.
REQ-007 SHALL have port: pls_data_indicate_byte  output  8  received frame byte, excluding preamble and SFD.
REQ-008 SHALL have port: pls_data_indicate_error  output  1  current byte was received with rx_er=1.
REQ-009 SHALL have port: pls_data_indicate_extend  output  1  one carrier-extend cycle received.
REQ-010 SHALL have port: pls_data_indicate_extenderror  output  1  one carrier-extend-error cycle received.
REQ-011 SHALL have port: pls_carrier_indicate  output  1  carrier present (frame or false carrier in progress).
REQ-012 SHALL have port: false_carrier  output  1  one-cycle pulse when a false-carrier code (rx_dv=0, rx_er=1, rxd=0x0E) is received.
REQ-013 SHALL have port: frame_done  output  1  one-cycle pulse at the end of a frame.
REQ-014 SHALL have port: frame_error  output  1  frame saw an rx_er or extend-error condition; valid when frame_done=1.
REQ-015 SHALL have port: byte_count  output  16  number of data bytes in the current or last frame; valid when frame_done=1.

Function
REQ-016 All outputs SHALL be registered, with exactly 1 cycle of latency from the GMII sample that causes them.
REQ-017 The state machine SHALL have the states IDLE, PREAMBLE, DATA, EXTEND and DROP.
REQ-018 IDLE transitions:
- rx_dv=1 with rxd=0x55 -> PREAMBLE.
- rx_dv=1 with rxd=0xD5 -> DATA.
- rx_dv=1 with any other rxd -> DROP.
REQ-019 PREAMBLE transitions:
- rxd=0x55 -> stay in PREAMBLE.
- rxd=0xD5 -> DATA.
- rx_dv=1 with any other rxd -> DROP.
- rx_dv=0 -> IDLE, with no frame_done.
REQ-020 On entering DATA, byte_count SHALL clear to 0 and frame_error SHALL clear.
REQ-021 In DATA with rx_dv=1, the block SHALL present the byte with pls_data_indicate_valid=1 and increment byte_count, saturating at 0xFFFF.
REQ-022 In DATA with rx_dv=1 and rx_er=1, the byte SHALL still be delivered with pls_data_indicate_error=1, and frame_error SHALL set and stay set until the next entry to DATA.
REQ-023 DATA exit when rx_dv=0:
- rx_er=1 and rxd=0x0F -> EXTEND, pulsing pls_data_indicate_extend.
- rx_er=1 and rxd=0x1F -> EXTEND, pulsing pls_data_indicate_extenderror and setting frame_error.
- Otherwise -> IDLE, pulsing frame_done.
REQ-024 EXTEND with rx_dv=0 and rx_er=1:
- rxd=0x0F -> pulse pls_data_indicate_extend.
- rxd=0x1F -> pulse pls_data_indicate_extenderror and set frame_error.
- Any other rxd -> treat as 0x1F.
REQ-025 EXTEND with rx_dv=0 and rx_er=0 -> IDLE, pulsing frame_done.
REQ-026 EXTEND with rx_dv=1 (frame bursting) SHALL pulse frame_done and, in the same cycle, apply the IDLE entry rules of REQ-018 to that sample.
REQ-027 DROP SHALL suppress all data outputs until rx_dv=0, then go to IDLE with no frame_done.
REQ-028 In IDLE, rx_dv=0 with rx_er=1 and rxd=0x0E SHALL pulse false_carrier; other rx_dv=0 codes in IDLE SHALL be ignored.
REQ-029 pls_carrier_indicate SHALL be 1 in PREAMBLE, DATA, EXTEND and DROP, and in the cycle a false carrier is flagged; otherwise it SHALL be 0.
REQ-030 byte_count and frame_error SHALL hold their values after frame_done until the next entry to DATA.

Reset
REQ-031 While reset=1, the state SHALL be IDLE and every output SHALL be 0, including byte_count=0x0000 and pls_data_indicate_byte=0x00.
REQ-032 A reset asserted mid-frame SHALL abort the frame with no frame_done pulse.
REQ-033 After reset, the next frame SHALL require a fresh preamble or SFD.

Structure
REQ-034 A shared package SHALL hold:
- The state encoding.
- The constants PREAMBLE_BYTE=0x55, SFD_BYTE=0xD5, FALSE_CARRIER=0x0E, CARRIER_EXT=0x0F and CARRIER_EXT_ERR=0x1F.
REQ-035 The Table 35-2 classification SHALL be a combinational sub-module, gmii_rx_decode, that maps (rx_dv, rx_er, rxd) to one of: idle, false_carrier, extend, extend_error, data, data_error, reserved.

Verification
REQ-036 Basic frame: 7x0x55, 0xD5, 64 data bytes 0x00..0x3F, then rx_dv=0 -> 64 valid pulses with bytes in order, then frame_done=1, byte_count=64, frame_error=0.
REQ-037 Data error: same frame with rx_er=1 on byte 10 -> byte 10 shows error=1; frame_done with frame_error=1 and byte_count=64.
REQ-038 Carrier extension: frame end followed by 3 cycles of (rx_dv=0, rx_er=1, rxd=0x0F) and then idle -> 3 extend pulses, then frame_done, frame_error=0; repeating with 0x1F in the 2nd cycle -> 1 extenderror pulse and frame_error=1.
REQ-039 False carrier and bad preamble:
- (rx_dv=0, rx_er=1, rxd=0x0E) in IDLE -> false_carrier pulse and carrier=1 for 1 cycle.
- Preamble 0x55, 0x55, 0xAA -> DROP, no valid and no frame_done.
REQ-040 Reset mid-frame after 20 data bytes -> all outputs 0 the cycle after, no frame_done; the next clean frame is received correctly.
REQ-041 Burst: a frame, 2 extend cycles, then rx_dv=1 with 0x55 -> frame_done for the first frame, then correct reception of the second frame.
